// File: rtl/rvee_fetch.sv
// Instruction fetch stage: issues in-order pipelined imem fetches for the pcgen stream,
// pairs responses with their PCs and hands {pc, insn} to decode; squashes on redirect.
module rvee_fetch #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            pc_valid,
  output logic            pc_ready,
  input  logic            jmp,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn,
  output logic [XLEN-1:0] insn_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_C = DEPTH[CW:0];

  logic [CW-1:0]   pc_wr_q, pc_wr_d, pc_rd_q, pc_rd_d;
  logic [CW-1:0]   resp_wr_q, resp_wr_d, resp_rd_q, resp_rd_d;
  logic [CW-1:0]   outst_q, outst_d, disc_q, disc_d;
  logic [XLEN-1:0] pc_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_d [DEPTH];
  logic [XLEN-1:0] rpc_mem_q [DEPTH];
  logic [XLEN-1:0] rpc_mem_d [DEPTH];
  logic [XLEN-1:0] rins_mem_q [DEPTH];
  logic [XLEN-1:0] rins_mem_d [DEPTH];

  logic [CW-1:0] resp_cnt;
  logic [CW:0]   cnt;
  logic          credit_ok, rvalid_eff, resp_push, resp_pop;

  always_comb begin
    resp_cnt   = resp_wr_q - resp_rd_q;
    cnt        = {1'b0, outst_q} + {1'b0, resp_cnt};
    credit_ok  = cnt < DEPTH_C;
    imem_req   = pc_valid & credit_ok & ~rst;
    pc_ready   = imem_req & imem_gnt;
    imem_addr  = {pc[XLEN-1:2], 2'b00};
    // A response with nothing outstanding is a bus protocol error and is ignored.
    rvalid_eff = imem_rvalid & (outst_q != '0);
    resp_push  = rvalid_eff & (disc_q == '0) & ~jmp;
    insn_valid = resp_wr_q != resp_rd_q;
    resp_pop   = insn_valid & insn_ready & ~jmp;
    insn       = rins_mem_q[resp_rd_q[AW-1:0]];
    insn_pc    = rpc_mem_q[resp_rd_q[AW-1:0]];
  end

  always_comb begin
    pc_wr_d    = pc_wr_q;
    pc_rd_d    = pc_rd_q;
    pc_mem_d   = pc_mem_q;
    resp_wr_d  = resp_wr_q;
    resp_rd_d  = resp_rd_q;
    rpc_mem_d  = rpc_mem_q;
    rins_mem_d = rins_mem_q;
    outst_d    = outst_q + CW'(pc_ready) - CW'(rvalid_eff);
    disc_d     = disc_q;

    if (pc_ready) begin
      pc_mem_d[pc_wr_q[AW-1:0]] = pc;
      pc_wr_d = pc_wr_q + 1'b1;
    end
    if (rvalid_eff) pc_rd_d = pc_rd_q + 1'b1;

    // Outstanding already counts pending discards, so after a redirect every request
    // still in flight (minus the one returning now) is to be dropped.
    if (jmp)
      disc_d = outst_q - CW'(rvalid_eff);
    else if (rvalid_eff && disc_q != '0)
      disc_d = disc_q - 1'b1;

    if (jmp) begin
      resp_rd_d = resp_wr_q;
    end else begin
      if (resp_push) begin
        rpc_mem_d[resp_wr_q[AW-1:0]]  = pc_mem_q[pc_rd_q[AW-1:0]];
        rins_mem_d[resp_wr_q[AW-1:0]] = imem_rdata;
        resp_wr_d = resp_wr_q + 1'b1;
      end
      if (resp_pop) resp_rd_d = resp_rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_wr_q    <= '0;
      pc_rd_q    <= '0;
      resp_wr_q  <= '0;
      resp_rd_q  <= '0;
      outst_q    <= '0;
      disc_q     <= '0;
      pc_mem_q   <= '{default: '0};
      rpc_mem_q  <= '{default: '0};
      rins_mem_q <= '{default: '0};
    end else begin
      pc_wr_q    <= pc_wr_d;
      pc_rd_q    <= pc_rd_d;
      resp_wr_q  <= resp_wr_d;
      resp_rd_q  <= resp_rd_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      pc_mem_q   <= pc_mem_d;
      rpc_mem_q  <= rpc_mem_d;
      rins_mem_q <= rins_mem_d;
    end
  end

endmodule

// File: tb/tb_rvee_fetch.sv
// Self-checking bench for rvee_fetch: directed vector table, hand-written flush/reset
// sequences and a randomized run against a queue-based reference model.
module tb_rvee_fetch;
  localparam int XLEN  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst, pc_valid, pc_ready, jmp, imem_req, imem_gnt, imem_rvalid;
  logic            insn_valid, insn_ready;
  logic [XLEN-1:0] pc, imem_addr, imem_rdata, insn, insn_pc;

  rvee_fetch #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready), .jmp(jmp),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; bit squash; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] ins; } resp_t;
  typedef struct {
    bit r, v; logic [31:0] p; bit j, g, rv, ir, chk;
    bit e_req, e_rdy, e_iv; logic [31:0] e_ipc;
  } vec_t;

  // Reference model: requests granted but unanswered, and instructions waiting for decode.
  pend_t       pend_q[$];
  resp_t       resp_q[$];
  logic [31:0] bus_q[$];

  int n_cmp = 0, n_bad = 0;
  bit cur_r, cur_v, cur_j, cur_g, cur_rv, cur_ir, cur_req;
  logic [31:0] cur_p;
  bit obs_rdy, obs_iv;
  logic [31:0] obs_ipc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_0000;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v, input logic [31:0] p, input bit j,
                               input bit g, input bit want_rv, input bit ir, input bit chk);
    bit rv;
    logic [31:0] rd;
    rv = want_rv && (bus_q.size() > 0);
    rd = rv ? data_of(bus_q.pop_front()) : $urandom();
    rst = r; pc_valid = v; pc = p; jmp = j; imem_gnt = g;
    imem_rvalid = rv; imem_rdata = rd; insn_ready = ir;
    #1;
    cur_r = r; cur_v = v; cur_p = p; cur_j = j; cur_g = g; cur_rv = rv; cur_ir = ir;
    cur_req = !r && v && ((pend_q.size() + resp_q.size()) < DEPTH);
    if (chk) begin
      checkOutput("imem_req", 32'(imem_req), 32'(cur_req));
      checkOutput("pc_ready", 32'(pc_ready), 32'(cur_req && g));
      if (cur_req) checkOutput("imem_addr", imem_addr, {p[31:2], 2'b00});
      checkOutput("insn_valid", 32'(insn_valid), 32'(resp_q.size() > 0));
      if (resp_q.size() > 0) begin
        checkOutput("insn_pc", insn_pc, resp_q[0].pc);
        checkOutput("insn", insn, resp_q[0].ins);
      end
    end
    obs_rdy = pc_ready; obs_iv = insn_valid; obs_ipc = insn_pc;
    if (imem_req && imem_gnt) bus_q.push_back(imem_addr);
  endtask

  task automatic next_cycle();
    pend_t e;
    bit fire;
    if (cur_r) begin
      pend_q.delete();
      resp_q.delete();
    end else begin
      fire = (resp_q.size() > 0) && cur_ir;
      if (cur_rv && pend_q.size() > 0) begin
        e = pend_q.pop_front();
        if (!e.squash && !cur_j) resp_q.push_back('{e.pc, data_of({e.pc[31:2], 2'b00})});
      end
      if (cur_j) begin
        resp_q.delete();
        foreach (pend_q[i]) pend_q[i].squash = 1'b1;
      end else if (fire) begin
        void'(resp_q.pop_front());
      end
      if (cur_req && cur_g) pend_q.push_back('{cur_p, 1'b0});
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit v, input logic [31:0] p, input bit j,
                      input bit g, input bit want_rv, input bit ir);
    applyStimulus(r, v, p, j, g, want_rv, ir, 1'b1);
    next_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    vec_t vecs[8];
    int grants, cnt_iv;
    logic [31:0] pcv, first_pc;
    bit seen;

    vecs[0] = '{1,0,32'h0,0,0,0,1, 0, 0,0,0,32'h0};
    vecs[1] = '{1,0,32'h0,0,0,0,1, 1, 0,0,0,32'h0};
    vecs[2] = '{0,1,32'h0,0,1,0,1, 1, 1,1,0,32'h0};
    vecs[3] = '{0,1,32'h4,0,1,1,1, 1, 1,1,0,32'h0};
    vecs[4] = '{0,1,32'h8,0,1,1,1, 1, 1,1,1,32'h0};
    vecs[5] = '{0,0,32'h0,0,0,1,1, 1, 0,0,1,32'h4};
    vecs[6] = '{0,0,32'h0,0,0,0,1, 1, 0,0,1,32'h8};
    vecs[7] = '{0,0,32'h0,0,0,0,1, 1, 0,0,0,32'h0};

    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].r, vecs[i].v, vecs[i].p, vecs[i].j, vecs[i].g, vecs[i].rv,
                    vecs[i].ir, vecs[i].chk);
      if (vecs[i].chk) begin
        checkOutput($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
        checkOutput($sformatf("vec%0d_rdy", i), 32'(pc_ready), 32'(vecs[i].e_rdy));
        checkOutput($sformatf("vec%0d_iv", i), 32'(insn_valid), 32'(vecs[i].e_iv));
        if (vecs[i].e_iv || vecs[i].r) checkOutput($sformatf("vec%0d_ipc", i), insn_pc, vecs[i].e_ipc);
        if (vecs[i].r) checkOutput($sformatf("vec%0d_insn", i), insn, 32'h0);
      end
      next_cycle();
    end

    // Backpressure: decode stalled, only DEPTH fetches may be granted.
    grants = 0; pcv = 32'h200;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, pcv, 1'b0, 1'b1, 1'b1, 1'b0);
      if (obs_rdy) begin grants++; pcv += 4; end
    end
    checkOutput("bp_grants", 32'(grants), 32'(DEPTH));
    grants = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, pcv, 1'b0, 1'b1, 1'b1, 1'b1);
      if (obs_rdy) begin grants++; pcv += 4; end
    end
    checkOutput("bp_resume", 32'(grants > 0), 32'h1);
    idle(10);

    // Flush with three requests in flight; the target granted in the jmp cycle survives.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h10 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("flush_target_granted", 32'(obs_rdy), 32'h1);
    seen = 0; cnt_iv = 0; first_pc = 32'hFFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      if (obs_iv) begin
        cnt_iv++;
        if (!seen) begin first_pc = obs_ipc; seen = 1; end
      end
    end
    checkOutput("flush_first_pc", first_pc, 32'h100);
    checkOutput("flush_insn_count", 32'(cnt_iv), 32'h1);

    // Flush with two instructions buffered for a stalled decode.
    step(1'b0, 1'b1, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("buf_valid_before_jmp", 32'(obs_iv), 32'h1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("buf_valid_after_jmp", 32'(obs_iv), 32'h0);
    idle(4);

    // Reset with three outstanding; the stale responses must be ignored.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'h80 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("rst_insn", insn, 32'h0);
    checkOutput("rst_insn_pc", insn_pc, 32'h0);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("rst_stale_ignored", 32'(obs_iv), 32'h0);
    end
    bus_q.delete();
    for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 32'hA0 + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("rst_full_credit", 32'(obs_rdy), 32'h1);
    idle(8);

    // Randomized traffic against the reference model.
    pcv = 32'h1000;
    for (int i = 0; i < 3000; i++) begin
      bit v, j, g, rv, ir;
      v  = $urandom_range(0, 9) < 7;
      j  = v && ($urandom_range(0, 9) == 0);
      if (j) pcv = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
      g  = $urandom_range(0, 9) < 7;
      rv = $urandom_range(0, 1) == 1;
      ir = $urandom_range(0, 9) < 6;
      step(1'b0, v, pcv, j, g, rv, ir);
      if (obs_rdy) pcv += 4;
    end
    idle(12);
    checkOutput("final_drained", 32'(obs_iv), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
